// File: rtl/instruction_fetch_pkg.sv
// ============================================================================
// Module      : instruction_fetch_pkg
// Description : Shared CPU constants, fetch FSM encoding and IF/ID layout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instruction_fetch_pkg;

  localparam logic [31:0] c_reset_pc   = 32'h0000_0000;
  localparam logic [31:0] c_nop_instr  = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] c_halt_instr = 32'hffff_ffff;

  localparam logic [0:0] c_st_fetch  = 1'b0;
  localparam logic [0:0] c_st_halted = 1'b1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } ifid_t;

endpackage

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
// Module      : instruction_fetch
// Description : PC register, halt-aware fetch FSM and IF/ID pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = c_reset_pc,
  parameter logic [31:0] NOP_INSTR  = c_nop_instr,
  parameter logic [31:0] HALT_INSTR = c_halt_instr
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [4:0]  rom_addr,
  input  logic [31:0] rom_instr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic        ifid_valid,
  output logic        halted
);

  logic [31:0] r_pc;
  logic [0:0]  r_state;
  ifid_t       r_ifid;
  logic        w_is_halt;
  logic        w_unused_misalign;

  assign rom_addr          = r_pc[6:2];
  assign w_is_halt         = (rom_instr == HALT_INSTR);
  // Misaligned target bits are dropped, not flagged.
  assign w_unused_misalign = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_state      <= c_st_fetch;
      r_ifid.instr <= NOP_INSTR;
      r_ifid.pc    <= 32'h0;
      r_ifid.valid <= 1'b0;
    end else if (redirect_valid) begin
      // Squash the in-flight fetch; a halt seen on the wrong path is abandoned.
      r_pc         <= {redirect_pc[31:2], 2'b00};
      r_state      <= c_st_fetch;
      r_ifid.instr <= NOP_INSTR;
      r_ifid.valid <= 1'b0;
    end else if (!stall) begin
      if (r_state == c_st_fetch) begin
        r_ifid.instr <= rom_instr;
        r_ifid.pc    <= r_pc;
        r_ifid.valid <= 1'b1;
        if (w_is_halt) begin
          r_state <= c_st_halted;
        end else begin
          r_pc <= r_pc + 32'd4;
        end
      end else begin
        r_ifid.instr <= NOP_INSTR;
        r_ifid.valid <= 1'b0;
      end
    end
  end

  assign ifid_instr = r_ifid.instr;
  assign ifid_pc    = r_ifid.pc;
  assign ifid_valid = r_ifid.valid;
  assign halted     = (r_state == c_st_halted);

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Scoreboard bench for instruction_fetch with a small ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'hffff_ffff;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        halted;
    logic [4:0]  addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [4:0]  rom_addr;
  logic [31:0] rom_instr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        ifid_valid;
  logic        halted;

  logic [31:0] rom [0:31];
  assign rom_instr = rom[rom_addr];

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb_q[$];

  // Reference state
  logic [31:0] m_pc, m_instr, m_ifpc;
  logic        m_valid, m_halted;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_addr       (rom_addr),
    .rom_instr      (rom_instr),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_valid     (ifid_valid),
    .halted         (halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the reference, then compare the popped expectation.
  task automatic step(input logic s_rst, input logic s_stall, input logic s_redir,
                      input logic [31:0] s_rpc);
    exp_t e;
    logic [31:0] w;
    rst            = s_rst;
    stall          = s_stall;
    redirect_valid = s_redir;
    redirect_pc    = s_rpc;
    if (s_rst) begin
      m_pc = 32'h0; m_halted = 1'b0; m_instr = NOP; m_ifpc = 32'h0; m_valid = 1'b0;
    end else if (s_redir) begin
      m_pc = {s_rpc[31:2], 2'b00}; m_halted = 1'b0; m_instr = NOP; m_valid = 1'b0;
    end else if (!s_stall) begin
      if (!m_halted) begin
        w = rom[m_pc[6:2]];
        m_instr = w; m_ifpc = m_pc; m_valid = 1'b1;
        if (w == HALT) m_halted = 1'b1;
        else           m_pc = m_pc + 32'd4;
      end else begin
        m_instr = NOP; m_valid = 1'b0;
      end
    end
    e.instr = m_instr; e.pc = m_ifpc; e.valid = m_valid;
    e.halted = m_halted; e.addr = m_pc[6:2];
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("sb_instr",  ifid_instr,          e.instr);
    check("sb_pc",     ifid_pc,             e.pc);
    check("sb_valid",  {31'h0, ifid_valid}, {31'h0, e.valid});
    check("sb_halted", {31'h0, halted},     {31'h0, e.halted});
    check("sb_addr",   {27'h0, rom_addr},   {27'h0, e.addr});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = NOP;
    rom[0] = 32'h00800293;
    rom[1] = 32'h00f00313;
    rom[4] = HALT;

    // Reset held two cycles
    step(1, 0, 0, 32'h0);
    step(1, 1, 1, 32'h40);
    check("rst_valid",  {31'h0, ifid_valid}, 32'h0);
    check("rst_halted", {31'h0, halted},     32'h0);
    check("rst_instr",  ifid_instr,          NOP);

    step(0, 0, 0, 32'h0);
    check("first_instr", ifid_instr, 32'h00800293);
    check("first_pc",    ifid_pc,    32'h0);

    // Stall three cycles with pc=4
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 32'h0);
      check("stall_instr", ifid_instr,        32'h00800293);
      check("stall_addr",  {27'h0, rom_addr}, 32'd1);
    end
    step(0, 0, 0, 32'h0);
    check("resume_instr", ifid_instr, 32'h00f00313);

    // Free-run into the halt word at pc=16
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    check("halt_instr", ifid_instr,          HALT);
    check("halt_valid", {31'h0, ifid_valid}, 32'h1);
    check("halt_pc",    ifid_pc,             32'd16);
    check("halt_flag",  {31'h0, halted},     32'h1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 32'h0);
      check("halted_valid", {31'h0, ifid_valid}, 32'h0);
      check("halted_flag",  {31'h0, halted},     32'h1);
      check("halted_addr",  {27'h0, rom_addr},   32'd4);
    end

    // Redirect out of HALTED
    step(0, 0, 1, 32'h0);
    check("hredir_halted", {31'h0, halted}, 32'h0);
    step(0, 0, 0, 32'h0);
    check("hredir_instr", ifid_instr, 32'h00800293);

    // Misaligned redirect beating a stall
    step(0, 1, 1, 32'h0000_0007);
    check("redir_valid", {31'h0, ifid_valid}, 32'h0);
    check("redir_addr",  {27'h0, rom_addr},   32'd1);
    step(0, 0, 0, 32'h0);
    check("redir_instr", ifid_instr, 32'h00f00313);

    // ROM address wrap
    step(0, 0, 1, 32'h0000_007c);
    check("wrap_addr31", {27'h0, rom_addr}, 32'd31);
    step(0, 0, 0, 32'h0);
    check("wrap_addr0", {27'h0, rom_addr}, 32'd0);
    check("wrap_pc",    ifid_pc,           32'h7c);

    // Reset overrides stall and redirect mid-run
    step(0, 1, 0, 32'h0);
    step(1, 1, 1, 32'h44);
    check("rst2_addr",  {27'h0, rom_addr},   32'd0);
    check("rst2_valid", {31'h0, ifid_valid}, 32'h0);
    step(0, 0, 0, 32'h0);
    check("rst2_instr", ifid_instr, 32'h00800293);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the bubble word (addi x0 x0 0).
REQ-003 SHALL have parameter HALT_INSTR, default 32'hffff_ffff, meaning the halt sentinel word.
REQ-004 SHALL have port clk, input, width 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, width 1, the reset; synchronous and active-high.
REQ-006 SHALL have port stall, input, width 1, the hazard-unit request to hold the PC and IF/ID.
REQ-007 SHALL have port redirect_valid, input, width 1, a taken branch or jump from a later stage.
REQ-008 SHALL have port redirect_pc, input, width 32, the byte-address target of the redirect.
REQ-009 SHALL have port rom_addr, output, width 5, the word address presented to the instruction ROM.
REQ-010 SHALL have port rom_instr, input, width 32, the combinational ROM data for rom_addr.
REQ-011 SHALL have port ifid_instr, output, width 32, the registered instruction for decode.
REQ-012 SHALL have port ifid_pc, output, width 32, the registered byte PC of ifid_instr.
REQ-013 SHALL have port ifid_valid, output, width 1, high when ifid_instr is a real fetched instruction.
REQ-014 SHALL have port halted, output, width 1, high while the fetch FSM is in HALTED.

Function
REQ-015 SHALL keep a 32-bit byte PC and drive rom_addr = pc[6:2] combinationally, with no extra register.
REQ-016 SHALL capture rom_instr and pc into IF/ID on the clock edge, giving one-cycle fetch-to-decode latency.
REQ-017 SHALL implement a two-state FSM: FETCH and HALTED.
REQ-018 In FETCH with no stall and no redirect, SHALL load IF/ID with {rom_instr, pc, valid=1} and set pc = pc + 4, modulo 2^32.
REQ-019 SHALL let rom_addr wrap from 31 to 0 when pc crosses a 128-byte boundary, with no error signalled.
REQ-020 In FETCH, when rom_instr == HALT_INSTR and there is no stall or redirect, SHALL load IF/ID with the halt word (valid=1), keep pc unchanged, and enter HALTED.
REQ-021 In HALTED without redirect, SHALL hold pc, load IF/ID with {NOP_INSTR, valid=0}, and keep halted=1.
REQ-022 When stall=1 and redirect_valid=0, SHALL hold pc, IF/ID and FSM state unchanged, in either state.
REQ-023 When redirect_valid=1, SHALL set pc = {redirect_pc[31:2], 2'b00} and load IF/ID with {NOP_INSTR, ifid_pc unchanged, valid=0}, squashing the in-flight fetch.
REQ-024 SHALL give redirect priority over stall and over halt detection in the same cycle.
REQ-025 SHALL return the FSM to FETCH when redirect_valid=1 in HALTED, treating the halt as wrong-path.
REQ-026 SHALL silently ignore misaligned redirect_pc bits [1:0].

Reset
REQ-027 When rst=1 at a clock edge, SHALL set pc=RESET_PC, FSM=FETCH, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_valid=0, halted=0.
REQ-028 SHALL give rst priority over stall and redirect, and SHALL abort any fetch, stall or halt in progress.
REQ-029 SHALL fetch the instruction at RESET_PC in the first cycle after rst deasserts.

Structure
REQ-030 SHALL place NOP_INSTR, HALT_INSTR, RESET_PC defaults and the FSM state encoding in the shared CPU package, for reuse by decode and hazard logic.
REQ-031 SHALL be a single module with no sub-modules; the ROM stays external and is connected by the parent.

Verification
REQ-032 The bench SHALL use a ROM model with word0=32'h00800293, word1=32'h00f00313, words 2-3 = NOP, and word4=32'hffff_ffff.
REQ-033 Scenario reset: rst high for 2 cycles -> ifid_valid=0, halted=0; one cycle after release, ifid_instr=32'h00800293 and ifid_pc=0.
REQ-034 Scenario halt: free-run -> at the edge fetching pc=16, ifid_instr=32'hffff_ffff and valid=1; halted=1 thereafter; rom_addr stays 4; ifid_valid=0 in following cycles.
REQ-035 Scenario stall: stall high for 3 cycles while pc=4 -> ifid_instr stays 32'h00800293, rom_addr stays 1, and fetch resumes with 32'h00f00313.
REQ-036 Scenario redirect: redirect_valid=1 with redirect_pc=32'h0000_0007 and stall=1 at the same time -> next cycle ifid_valid=0 and pc=4; the following cycle ifid_instr=32'h00f00313.
REQ-037 Scenario halted redirect and wrap: redirect to 0 while halted -> halted=0 and fetch restarts at word0; separately, redirect to 32'h0000_007c -> rom_addr=31, then 0.
